// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter with per-port lock that shares one single-port data memory.
// Define DM_ARB_STATS_EN to add grant and forced-release statistics counters.
module dm_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wd,
    input  logic [DATA_W-1:0] dm_rd,
    output logic [1:0]        dbg_state
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [7:0]        stat_force
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               last, last_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic               force_rel;

    assign dbg_state = state;

    // Handshake: a requester holds req/addr/we/wd/lock stable until gnt is seen high at a
    // posedge; the transfer completes on that edge, and at most one gnt is high per cycle.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        force_rel    = 1'b0;
        if (rst_n) begin
            unique case (state)
                ARB: begin
                    if (req0 && req1) begin
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                    if (gnt0 && lock0) begin
                        state_nxt    = LOCK0;
                        lock_cnt_nxt = CNT_W'(1);
                    end else if (gnt1 && lock1) begin
                        state_nxt    = LOCK1;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
                LOCK0: begin
                    gnt0 = req0;
                    if (lock_cnt == CNT_W'(LOCK_MAX)) begin
                        force_rel    = 1'b1;
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end else if (gnt0 && !lock0) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
                LOCK1: begin
                    gnt1 = req1;
                    if (lock_cnt == CNT_W'(LOCK_MAX)) begin
                        force_rel    = 1'b1;
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end else if (gnt1 && !lock1) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end
            endcase
            if (gnt0) begin
                last_nxt = 1'b0;
            end else if (gnt1) begin
                last_nxt = 1'b1;
            end
            // A forced release counts as the locked port's turn so the other port wins the next tie.
            if (force_rel) begin
                last_nxt = (state == LOCK1);
            end
        end
    end

    always_comb begin
        dm_addr = '0;
        dm_wd   = '0;
        dm_we   = 1'b0;
        if (gnt0) begin
            dm_addr = addr0;
            dm_wd   = wd0;
            dm_we   = we0;
        end else if (gnt1) begin
            dm_addr = addr1;
            dm_wd   = wd1;
            dm_we   = we1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
            rvalid0  <= gnt0 && !we0;
            rvalid1  <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0 <= dm_rd;
            end
            if (gnt1 && !we1) begin
                rdata1 <= dm_rd;
            end
        end
    end

`ifdef DM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_gnt0  <= '0;
            stat_gnt1  <= '0;
            stat_force <= '0;
        end else begin
            if (gnt0 && stat_gnt0 != 16'hFFFF) begin
                stat_gnt0 <= stat_gnt0 + 16'd1;
            end
            if (gnt1 && stat_gnt1 != 16'hFFFF) begin
                stat_gnt1 <= stat_gnt1 + 16'd1;
            end
            if (force_rel && stat_force != 8'hFF) begin
                stat_force <= stat_force + 8'd1;
            end
        end
    end
`endif

endmodule
